// File: rtl/decision_engine.sv
`default_nettype none
// ============================================================================
//  Module      : decision_engine
//  Description : Per-channel buy/sell volume threshold evaluation with one
//                pending decision per channel, round-robin arbitration onto a
//                single tx path and a request/done handshake guarded by a
//                watchdog.
//                Optional build macro PRICE_CHECK_EN: when defined, a buy or
//                sell decision additionally requires a non-zero price on the
//                corresponding side; otherwise prices are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module decision_engine #(
    parameter int                NUM_CH     = 4,
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] VOL_THRESH = 32'h000A0000,
    parameter int                TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [DATA_W-1:0] rx_buyprice,
    input  logic [DATA_W-1:0] rx_sellprice,
    input  logic [DATA_W-1:0] rx_buyvol,
    input  logic [DATA_W-1:0] rx_sellvol,
    input  logic              rx_dv,
    output logic              tx_req,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] tx_addr,
    output logic [7:0]        tx_buysell,
    output logic              busy,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       bad_addr_cnt,
    output logic              err_timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_ch_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          c_wd_w    = $clog2(TIMEOUT);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

    localparam logic [1:0]  c_code_hold = 2'd0;
    localparam logic [1:0]  c_code_sell = 2'd1;
    localparam logic [1:0]  c_code_buy  = 2'd2;

    localparam logic [15:0] c_cnt_max   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                    state_q;
    logic [NUM_CH-1:0]         pend_q;
    logic [NUM_CH-1:0][1:0]    code_q;
    logic [c_ch_w-1:0]         rr_q;
    logic [c_wd_w-1:0]         wd_q;
    logic [ADDR_W-1:0]         tx_addr_q;
    logic [7:0]                tx_buysell_q;
    logic                      tx_req_q;
    logic                      busy_q;
    logic                      err_q;
    logic [15:0]               drop_cnt_q;
    logic [15:0]               bad_cnt_q;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                      w_buy_ok;
    logic                      w_sell_ok;
    logic [1:0]                w_dec;
    logic                      w_addr_ok;
    logic [c_ch_w-1:0]         w_rx_ch;
    logic                      w_any;
    logic [c_ch_w-1:0]         w_gnt_ch;
    logic                      w_grant;
    logic                      w_capture;
    logic                      w_consume;

    // Channel index offset by 'off' positions, wrapping at NUM_CH.
    function automatic logic [c_ch_w-1:0] f_wrap(input logic [c_ch_w-1:0] base,
                                                 input int                off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return s[c_ch_w-1:0];
    endfunction

`ifndef PRICE_CHECK_EN
    // Prices only matter when the price check is built in.
    logic w_unused_prices;
    assign w_unused_prices = ^{rx_buyprice, rx_sellprice};
`endif

    // Threshold decision on the current rx beat; buy takes precedence.
    always_comb begin
`ifdef PRICE_CHECK_EN
        w_buy_ok  = (rx_buyvol  > VOL_THRESH) && (rx_buyprice  != '0);
        w_sell_ok = (rx_sellvol > VOL_THRESH) && (rx_sellprice != '0);
`else
        w_buy_ok  = (rx_buyvol  > VOL_THRESH);
        w_sell_ok = (rx_sellvol > VOL_THRESH);
`endif
        if (w_buy_ok) begin
            w_dec = c_code_buy;
        end else if (w_sell_ok) begin
            w_dec = c_code_sell;
        end else begin
            w_dec = c_code_hold;
        end
    end

    assign w_addr_ok = (rx_addr < ADDR_W'(NUM_CH));
    assign w_rx_ch   = rx_addr[c_ch_w-1:0];
    assign w_capture = rx_dv && w_addr_ok && (w_dec != c_code_hold);

    // Round-robin search from rr_q upward; the lowest offset that is pending wins.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pend_q[f_wrap(rr_q, k)]) begin
                w_any    = 1'b1;
                w_gnt_ch = f_wrap(rr_q, k);
            end
        end
    end

    assign w_grant   = (state_q == S_IDLE) && w_any;
    assign w_consume = w_grant && (w_gnt_ch == w_rx_ch);

    // Pending table and rx-side counters; a capture overrides a same-cycle grant clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= '0;
            code_q     <= '0;
            drop_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            if (w_grant) begin
                pend_q[w_gnt_ch] <= 1'b0;
            end
            if (w_capture) begin
                pend_q[w_rx_ch] <= 1'b1;
                code_q[w_rx_ch] <= w_dec;
                if (pend_q[w_rx_ch] && !w_consume && (drop_cnt_q != c_cnt_max)) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
            if (rx_dv && !w_addr_ok && (bad_cnt_q != c_cnt_max)) begin
                bad_cnt_q <= bad_cnt_q + 16'd1;
            end
        end
    end

    // Issue FSM: grant, one-cycle request pulse, then wait for done or watchdog abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            wd_q         <= '0;
            tx_addr_q    <= '0;
            tx_buysell_q <= '0;
            tx_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (w_any) begin
                        tx_addr_q    <= ADDR_W'(w_gnt_ch);
                        tx_buysell_q <= {6'd0, code_q[w_gnt_ch]};
                        rr_q         <= f_wrap(w_gnt_ch, 1);
                        tx_req_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_req_q <= 1'b0;
                    wd_q     <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wd_q == c_wd_last) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + c_wd_w'(1);
                    end
                end
                default: begin
                    tx_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_req       = tx_req_q;
    assign tx_addr      = tx_addr_q;
    assign tx_buysell   = tx_buysell_q;
    assign busy         = busy_q;
    assign drop_cnt     = drop_cnt_q;
    assign bad_addr_cnt = bad_cnt_q;
    assign err_timeout  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decision_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_decision_engine
//  Description : Scoreboard bench for decision_engine. Stimulus pushes the
//                expected tx decisions; a monitor pops and compares on every
//                tx_req pulse. Directed checks cover reset, counters, latency,
//                watchdog abort and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decision_engine;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;

    localparam logic [31:0] c_over  = 32'h000A0001;
    localparam logic [31:0] c_equal = 32'h000A0000;
    localparam logic [31:0] c_big   = 32'h000B0000;
    localparam logic [31:0] c_low   = 32'h00010000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] rx_addr = '0;
    logic [DATA_W-1:0] rx_buyprice = '0;
    logic [DATA_W-1:0] rx_sellprice = '0;
    logic [DATA_W-1:0] rx_buyvol = '0;
    logic [DATA_W-1:0] rx_sellvol = '0;
    logic              rx_dv = 1'b0;
    logic              tx_req;
    logic              tx_done = 1'b0;
    logic [ADDR_W-1:0] tx_addr;
    logic [7:0]        tx_buysell;
    logic              busy;
    logic [15:0]       drop_cnt;
    logic [15:0]       bad_addr_cnt;
    logic              err_timeout;

    decision_engine #(
        .NUM_CH     (NUM_CH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .VOL_THRESH (32'h000A0000),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_addr      (rx_addr),
        .rx_buyprice  (rx_buyprice),
        .rx_sellprice (rx_sellprice),
        .rx_buyvol    (rx_buyvol),
        .rx_sellvol   (rx_sellvol),
        .rx_dv        (rx_dv),
        .tx_req       (tx_req),
        .tx_done      (tx_done),
        .tx_addr      (tx_addr),
        .tx_buysell   (tx_buysell),
        .busy         (busy),
        .drop_cnt     (drop_cnt),
        .bad_addr_cnt (bad_addr_cnt),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic auto_done = 1'b1;
    int   done_delay = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_tx(input logic [7:0] a, input logic [7:0] c);
        exp_t e;
        e.addr = a;
        e.code = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every tx_req pulse must match the oldest expected decision.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && tx_req) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_tx: got addr %0d code %0d required no request",
                         tx_addr, tx_buysell);
            end else begin
                e = exp_q.pop_front();
                check("tx_addr", 32'(tx_addr), 32'(e.addr));
                check("tx_buysell", 32'(tx_buysell), 32'(e.code));
            end
        end
    end

    // Timestamp stand-in: answers each request done_delay cycles into WAIT.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && tx_req && auto_done) begin
                repeat (done_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx(input logic [7:0] a, input logic [31:0] bv, input logic [31:0] sv,
                      input logic [31:0] bp, input logic [31:0] sp);
        rx_addr      = a;
        rx_buyvol    = bv;
        rx_sellvol   = sv;
        rx_buyprice  = bp;
        rx_sellprice = sp;
        rx_dv        = 1'b1;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check({name, "_drained"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tx_req"}, 32'(tx_req), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_tx_addr"}, 32'(tx_addr), 32'd0);
        check({name, "_tx_buysell"}, 32'(tx_buysell), 32'd0);
        check({name, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        check({name, "_bad_addr_cnt"}, 32'(bad_addr_cnt), 32'd0);
        check({name, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        int i;
        // ---------------- reset ----------------
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // ---------------- 1: buy on ch0, latency ----------------
        expect_tx(8'd0, 8'd2);
        rx(8'd0, c_over, 32'd0, 32'd1, 32'd1);
        @(negedge clk);
        check("t1_no_req_grant_cycle", 32'(tx_req), 32'd0);
        @(negedge clk);
        check("t1_req_at_n_plus_2", 32'(tx_req), 32'd1);
        check("t1_busy_in_issue", 32'(busy), 32'd1);
        drain("t1");
        check("t1_busy_after_done", 32'(busy), 32'd0);
        done_delay = 1;

        // ---------------- 2: equal buyvol -> sell; hold -> nothing ----------------
        expect_tx(8'd1, 8'd1);
        rx(8'd1, c_equal, c_big, 32'd1, 32'd1);
        drain("t2_sell");
        rx(8'd1, c_low, c_low, 32'd1, 32'd1);
        tick(10);
        check("t2_hold_idle", 32'(busy), 32'd0);

        // ---------------- 3: round-robin order and wrap ----------------
        done_delay = 6;
        expect_tx(8'd0, 8'd2);
        expect_tx(8'd1, 8'd1);
        expect_tx(8'd2, 8'd1);
        expect_tx(8'd3, 8'd1);
        rx(8'd0, c_over, 32'd0, 32'd1, 32'd1);
        rx(8'd3, 32'd0, c_big, 32'd1, 32'd1);
        rx(8'd1, 32'd0, c_big, 32'd1, 32'd1);
        rx(8'd2, 32'd0, c_big, 32'd1, 32'd1);
        drain("t3_order");
        expect_tx(8'd3, 8'd2);
        expect_tx(8'd0, 8'd1);
        expect_tx(8'd1, 8'd1);
        rx(8'd3, c_over, 32'd0, 32'd1, 32'd1);
        rx(8'd1, 32'd0, c_big, 32'd1, 32'd1);
        rx(8'd0, 32'd0, c_big, 32'd1, 32'd1);
        drain("t3_wrap");

        // ---------------- 4: overwrite while pending -> drop ----------------
        expect_tx(8'd0, 8'd2);
        expect_tx(8'd2, 8'd1);
        rx(8'd0, c_over, 32'd0, 32'd1, 32'd1);
        rx(8'd2, c_over, 32'd0, 32'd1, 32'd1);
        rx(8'd2, 32'd0, c_big, 32'd1, 32'd1);
        drain("t4_drop");
        check("t4_drop_cnt", 32'(drop_cnt), 32'd1);

        // capture on the channel being granted: old code issued, new one stays pending
        expect_tx(8'd1, 8'd2);
        expect_tx(8'd1, 8'd1);
        rx(8'd1, c_over, 32'd0, 32'd1, 32'd1);
        rx(8'd1, 32'd0, c_big, 32'd1, 32'd1);
        drain("t4_collide");
        check("t4_collide_no_drop", 32'(drop_cnt), 32'd1);

        // ---------------- 5: bad address, watchdog ----------------
        rx(8'd7, c_over, 32'd0, 32'd1, 32'd1);
        tick(5);
        check("t5_bad_addr_cnt", 32'(bad_addr_cnt), 32'd1);
        check("t5_bad_no_busy", 32'(busy), 32'd0);
        auto_done = 1'b0;
        expect_tx(8'd3, 8'd2);
        expect_tx(8'd0, 8'd1);
        rx(8'd3, c_over, 32'd0, 32'd1, 32'd1);
        rx(8'd0, 32'd0, c_big, 32'd1, 32'd1);
        i = 0;
        @(negedge clk);
        while (!tx_req && i < 10) begin
            @(negedge clk);
            i++;
        end
        check("t5_req_seen", 32'(tx_req), 32'd1);
        repeat (TIMEOUT - 2) @(posedge clk);
        #1;
        check("t5_err_not_yet", 32'(err_timeout), 32'd0);
        check("t5_still_waiting", 32'(busy), 32'd1);
        auto_done = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_err_timeout", 32'(err_timeout), 32'd1);
        drain("t5_after_abort");
        check("t5_err_sticky", 32'(err_timeout), 32'd1);

        // ---------------- 6: reset during WAIT ----------------
        auto_done = 1'b0;
        expect_tx(8'd1, 8'd2);
        rx(8'd1, c_over, 32'd0, 32'd1, 32'd1);
        rx(8'd2, 32'd0, c_big, 32'd1, 32'd1);
        rx(8'd3, c_over, 32'd0, 32'd1, 32'd1);
        tick(3);
        check("t6_in_wait", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        tick(2);
        reset_n = 1'b1;
        auto_done = 1'b1;
        tick(20);
        check("t6_no_req_after_reset", 32'(busy), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- 7: price check ----------------
`ifdef PRICE_CHECK_EN
        expect_tx(8'd0, 8'd1);
`else
        expect_tx(8'd0, 8'd2);
`endif
        rx(8'd0, c_big, c_big, 32'd0, 32'd5);
        drain("t7_price");

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decision_engine.md
Name: decision_engine

Overview:
- Parametrised successor to the single-address loopback decision logic in `system`.
- Evaluates buy/sell volume thresholds for NUM_CH independent book addresses.
- Holds one pending decision per channel and round-robin arbitrates pending decisions onto a single tx path.
- Sits between rx_mux and the timestamp/tx_mux path, handshaking with timestamp via a request/done pair and a watchdog.

Parameters:
- NUM_CH, 4, number of book channels (addresses 0..NUM_CH-1), range 1..16
- ADDR_W, 8, address width
- DATA_W, 32, price/volume width
- VOL_THRESH, 32'h000A0000, volume threshold; strict greater-than compare
- TIMEOUT, 64, max cycles in WAIT before abort, must be ≥ 2

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_addr  in  ADDR_W  channel address of rx update
- rx_buyprice  in  DATA_W  best buy price
- rx_sellprice  in  DATA_W  best sell price
- rx_buyvol  in  DATA_W  buy volume
- rx_sellvol  in  DATA_W  sell volume
- rx_dv  in  1  rx update valid, single-cycle qualifier
- tx_req  out  1  one-cycle pulse to timestamp tx_dv_in
- tx_done  in  1  timestamp tx_dv_out, completion of current request
- tx_addr  out  ADDR_W  channel of current/last issued decision
- tx_buysell  out  8  decision code: 0 hold, 1 sell, 2 buy
- busy  out  1  high in ISSUE or WAIT
- drop_cnt  out  16  saturating count of overwritten pending decisions
- bad_addr_cnt  out  16  saturating count of rx_dv with rx_addr ≥ NUM_CH
- err_timeout  out  1  sticky; set on watchdog abort

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM=IDLE, all pending bits 0, rr pointer 0, watchdog 0.
- Decision, combinational on rx inputs:
  - buy (2) if rx_buyvol > VOL_THRESH.
  - else sell (1) if rx_sellvol > VOL_THRESH.
  - else hold (0).
  - Unsigned compare.
- Capture, registered on rx_dv with rx_addr < NUM_CH:
  - Hold: the channel's pending bit is not changed.
  - Buy or sell: pend[ch] <= 1, code[ch] <= decision.
  - If pend[ch] was already 1 and is not being consumed this cycle: drop_cnt += 1, saturating at 16'hFFFF; the new code overwrites.
- Bad address: rx_dv with rx_addr ≥ NUM_CH → bad_addr_cnt += 1 (saturating); no other effect.
- Arbiter:
  - Round-robin over pend[], searching from rr pointer upward with wrap.
  - On grant, rr pointer <= granted ch + 1 (mod NUM_CH).
- FSM states:
  - IDLE: if any pend set → grant ch; tx_addr <= ch, tx_buysell <= code[ch], clear pend[ch]; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: tx_req=1 for exactly this one cycle; watchdog <= 0; go to WAIT.
  - WAIT:
    - tx_done=1 → IDLE.
    - Otherwise watchdog++; at watchdog == TIMEOUT-1 → err_timeout <= 1, go to IDLE.
- Latency: rx_dv on an empty idle engine → tx_req asserted 2 cycles later (capture cycle N, grant N+1, tx_req N+2).
- Throughput: minimum 3 cycles per decision (IDLE, ISSUE, WAIT with same-cycle done).
- Simultaneous events:
  - rx capture to the channel being granted in the same cycle: the clear loses, pend stays 1 with the new code, no drop counted. The granted (old) code is issued.
  - tx_done while in IDLE or ISSUE is ignored.
- tx_addr and tx_buysell hold their last values until the next grant.
- rx_buyprice and rx_sellprice are unused unless PRICE_CHECK_EN is defined.
- Reset mid-operation (any state): immediate return to reset values; pending decisions are lost; err_timeout cleared.

Optional Feature:
- Macro: PRICE_CHECK_EN.
- Defined:
  - Buy additionally requires rx_buyprice != 0.
  - Sell additionally requires rx_sellprice != 0.
  - A failed check yields hold; e.g. buyvol over threshold with buyprice 0 falls through to the sell check.
- Undefined: prices ignored; decision is volume-only as above.

Test Plan:
1. Reset, then rx_dv addr=0, buyvol=32'h000A0001, sellvol=0 → tx_req pulse 2 cycles later, tx_addr=0, tx_buysell=2; tx_done 3 cycles later → busy=0.
2. buyvol=32'h000A0000 (equal), sellvol=32'h000B0000 on addr 1 → tx_buysell=1. Then both volumes 32'h00010000 → no tx_req for 10 cycles.
3. Same cycle-group: rx to addr 3, 1, 2 (sell) while busy → issue order 1, 2, 3 after the current request. Then rr wraps, so the next pending on ch0 issues before ch1.
4. Two rx to addr 2 while busy, first buy then sell → drop_cnt=1; a single tx with tx_buysell=1.
5. rx_dv addr=8'd7 with NUM_CH=4 → bad_addr_cnt=1, no tx_req. Then withhold tx_done after a valid request → err_timeout=1 after TIMEOUT cycles, FSM back to IDLE, next pending issued.
6. Assert reset_n=0 during WAIT with 2 channels pending → all outputs 0 immediately; after release, no tx_req. With PRICE_CHECK_EN: buyvol high, buyprice=0, sellvol high, sellprice=5 → tx_buysell=1.
